// File: rtl/arith_op_sequencer.sv
// arith_op_sequencer: command FIFO, registered issue stage and result register
// in front of the 3-bit arithmetic datapath. The sequencer also recomputes
// each result to report signed overflow and datapath mismatches.
module arith_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    // command side
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [2:0]      cmd_a,
    input  logic [2:0]      cmd_b,
    // datapath side
    output logic            s0,
    output logic            s1,
    output logic [2:0]      a,
    output logic [2:0]      b,
    input  logic [2:0]      g,
    // result side
    output logic            res_valid,
    input  logic            res_ready,
    output logic [2:0]      res_g,
    output logic [1:0]      res_op,
    output logic            res_ovf,
    output logic            res_err,
    output logic [ERRW-1:0] err_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
    } cmd_t;

    // FIFO storage and bookkeeping
    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ready_d;

    // issue stage (drives the datapath)
    logic            iss_valid_q, iss_valid_d;
    cmd_t            iss_q, iss_d;

    // result register
    logic            res_valid_q, res_valid_d;
    logic [2:0]      res_g_q, res_g_d;
    logic [1:0]      res_op_q, res_op_d;
    logic            res_ovf_q, res_ovf_d;
    logic            res_err_q, res_err_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    // handshake and reference-result signals
    cmd_t            cmd_in_c;
    logic            push_c;
    logic            pop_c;
    logic            adv_c;
    logic [3:0]      sa_c;
    logic [3:0]      sb_c;
    logic [3:0]      exp_c;
    logic            ovf_c;
    logic            err_c;

    // Handshake decode: ready is registered, so a full FIFO stays blocked
    // even on an edge that also pops.
    always_comb begin
        cmd_in_c    = '0;
        cmd_in_c.op = cmd_op;
        cmd_in_c.a  = cmd_a;
        cmd_in_c.b  = cmd_b;
        push_c      = cmd_valid & ready_q;
        adv_c       = ~res_valid_q | res_ready;
        pop_c       = adv_c & (count_q != '0);
    end

    // 4-bit signed reference result from the issue-stage operands
    always_comb begin
        sa_c  = {iss_q.a[2], iss_q.a};
        sb_c  = {iss_q.b[2], iss_q.b};
        exp_c = '0;
        case (iss_q.op)
            2'b00:   exp_c = sa_c - 4'd1;
            2'b01:   exp_c = sa_c + sb_c;
            2'b10:   exp_c = sa_c - sb_c;
            default: exp_c = 4'd0 - sb_c;
        endcase
        // outside -4..3 exactly when the top two bits disagree
        ovf_c = exp_c[3] ^ exp_c[2];
        err_c = (exp_c[2:0] != g);
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_c) - CW'(pop_c);
        ready_d = (count_d != FULL);
    end

    // Issue stage and result register advance together when the result
    // slot is empty or being consumed; otherwise everything holds.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        res_valid_d = res_valid_q;
        res_g_d     = res_g_q;
        res_op_d    = res_op_q;
        res_ovf_d   = res_ovf_q;
        res_err_d   = res_err_q;
        err_cnt_d   = err_cnt_q;
        if (adv_c) begin
            res_valid_d = iss_valid_q;
            if (iss_valid_q) begin
                res_g_d   = g;
                res_op_d  = iss_q.op;
                res_ovf_d = ovf_c;
                res_err_d = err_c;
                if (err_c && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERRW'(1);
                end
            end
            iss_valid_d = pop_c;
            // datapath fields keep their last values when nothing issues
            if (pop_c) begin
                iss_d = mem_q[rd_ptr_q];
            end
        end
    end

    // FIFO storage write; entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            res_valid_q <= 1'b0;
            res_g_q     <= '0;
            res_op_q    <= '0;
            res_ovf_q   <= 1'b0;
            res_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            res_valid_q <= res_valid_d;
            res_g_q     <= res_g_d;
            res_op_q    <= res_op_d;
            res_ovf_q   <= res_ovf_d;
            res_err_q   <= res_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Output mapping straight from registers
    assign cmd_ready = ready_q;
    assign s0        = iss_q.op[0];
    assign s1        = iss_q.op[1];
    assign a         = iss_q.a;
    assign b         = iss_q.b;
    assign res_valid = res_valid_q;
    assign res_g     = res_g_q;
    assign res_op    = res_op_q;
    assign res_ovf   = res_ovf_q;
    assign res_err   = res_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Testbench for arith_op_sequencer: models the datapath, keeps an ordered
// scoreboard of expected results, and runs directed and random phases.
module tb_arith_op_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ERRW  = 8;
    localparam int          ERR_MAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [2:0]      cmd_a;
    logic [2:0]      cmd_b;
    logic            s0;
    logic            s1;
    logic [2:0]      a;
    logic [2:0]      b;
    logic [2:0]      g;
    logic            res_valid;
    logic            res_ready;
    logic [2:0]      res_g;
    logic [1:0]      res_op;
    logic            res_ovf;
    logic            res_err;
    logic [ERRW-1:0] err_cnt;

    logic            force_zero;

    typedef struct {
        logic [1:0] op;
        logic [2:0] g;
        logic       ovf;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fails;
    int   n_pushed;
    int   n_xfer;
    int   n_err_exp;

    arith_op_sequencer #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .s0        (s0),
        .s1        (s1),
        .a         (a),
        .b         (b),
        .g         (g),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_g     (res_g),
        .res_op    (res_op),
        .res_ovf   (res_ovf),
        .res_err   (res_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // true signed result of an operation, as a plain integer
    function automatic int true_val(input logic [1:0] op, input logic [2:0] av3, input logic [2:0] bv3);
        int av;
        int bv;
        av = $signed(av3);
        bv = $signed(bv3);
        case (op)
            2'd0:    return av - 1;
            2'd1:    return av + bv;
            2'd2:    return av - bv;
            default: return -bv;
        endcase
    endfunction

    // datapath model, with an optional stuck-at-zero fault for self-check tests
    always_comb begin
        g = 3'(true_val({s1, s0}, a, b));
        if (force_zero) g = 3'b000;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: score any result transfer and command push, then cross the edge
    task automatic step();
        exp_t e;
        int   v;
        if (res_valid && res_ready) begin
            n_xfer++;
            if (sb_q.size() == 0) begin
                chk("no_stale_result", 32'(res_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_res_g",   32'(res_g),   32'(e.g));
                chk("sb_res_op",  32'(res_op),  32'(e.op));
                chk("sb_res_ovf", 32'(res_ovf), 32'(e.ovf));
                chk("sb_res_err", 32'(res_err), 32'(e.err));
            end
        end
        if (cmd_valid && cmd_ready && !rst) begin
            v     = true_val(cmd_op, cmd_a, cmd_b);
            e.op  = cmd_op;
            e.ovf = (v < -4) || (v > 3);
            e.g   = force_zero ? 3'b000 : 3'(v);
            e.err = (e.g != 3'(v));
            if (e.err) n_err_exp++;
            sb_q.push_back(e);
            n_pushed++;
        end
        @(posedge clk);
        #1;
        chk("inflight_cap", 32'((n_pushed - n_xfer) <= int'(DEPTH + 2)), 32'd1);
    endtask

    task automatic push_one(input logic [1:0] op, input logic [2:0] av, input logic [2:0] bv);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = av;
        cmd_b     = bv;
        chk("push_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k;
        k         = 0;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        while (sb_q.size() != 0 && k < limit) begin
            step();
            k++;
        end
        chk("drain_done", 32'(sb_q.size()), 32'd0);
        step();
    endtask

    // single command through an empty pipeline, checking latency and value
    task automatic basic(input string tag, input logic [1:0] op, input logic [2:0] av,
                         input logic [2:0] bv, input logic [2:0] g_exp, input logic ovf_exp,
                         input logic err_exp);
        res_ready = 1'b1;
        push_one(op, av, bv);
        chk({tag, "_early_valid"}, 32'(res_valid), 32'd0);
        step();
        chk({tag, "_dp_op"}, 32'({s1, s0}), 32'(op));
        chk({tag, "_dp_a"},  32'(a), 32'(av));
        chk({tag, "_dp_b"},  32'(b), 32'(bv));
        chk({tag, "_e1_valid"}, 32'(res_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_g"},     32'(res_g),     32'(g_exp));
        chk({tag, "_op"},    32'(res_op),    32'(op));
        chk({tag, "_ovf"},   32'(res_ovf),   32'(ovf_exp));
        chk({tag, "_err"},   32'(res_err),   32'(err_exp));
        step();
    endtask

    function automatic int sat_err();
        return (n_err_exp > ERR_MAX) ? ERR_MAX : n_err_exp;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bp_op [8];
        logic [2:0] bp_a  [8];
        logic [2:0] bp_b  [8];
        logic [2:0] first_g;
        int         acc;
        int         xfer0;

        n_checks   = 0;
        n_fails    = 0;
        n_pushed   = 0;
        n_xfer     = 0;
        n_err_exp  = 0;
        force_zero = 1'b0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_a      = 3'b000;
        cmd_b      = 3'b000;
        res_ready  = 1'b0;

        // reset values
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_s0",        32'(s0),        32'd0);
        chk("rst_s1",        32'(s1),        32'd0);
        chk("rst_a",         32'(a),         32'd0);
        chk("rst_b",         32'(b),         32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_g",     32'(res_g),     32'd0);
        chk("rst_res_op",    32'(res_op),    32'd0);
        chk("rst_res_ovf",   32'(res_ovf),   32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);

        // basic ops and overflow corners
        basic("add",     2'b01, 3'b110, 3'b111, 3'b101, 1'b0, 1'b0);
        basic("sub",     2'b10, 3'b110, 3'b111, 3'b111, 1'b0, 1'b0);
        basic("neg",     2'b11, 3'b110, 3'b111, 3'b001, 1'b0, 1'b0);
        basic("dec_ovf", 2'b00, 3'b100, 3'b000, 3'b011, 1'b1, 1'b0);
        basic("add_ovf", 2'b01, 3'b011, 3'b011, 3'b110, 1'b1, 1'b0);
        basic("neg_ovf", 2'b11, 3'b000, 3'b100, 3'b100, 1'b1, 1'b0);
        chk("sb_empty_basic", 32'(sb_q.size()), 32'd0);

        // backpressure: 8 offered with res_ready low, DEPTH+2 accepted
        res_ready = 1'b0;
        acc       = 0;
        for (int i = 0; i < 8; i++) begin
            bp_op[i]  = 2'($urandom);
            bp_a[i]   = 3'($urandom);
            bp_b[i]   = 3'($urandom);
            cmd_valid = 1'b1;
            cmd_op    = bp_op[i];
            cmd_a     = bp_a[i];
            cmd_b     = bp_b[i];
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_accepted",  32'(acc),       32'(DEPTH + 2));
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        first_g = 3'(true_val(bp_op[0], bp_a[0], bp_b[0]));
        for (int i = 0; i < 3; i++) begin
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_g",     32'(res_g),     32'(first_g));
            chk("bp_res_op",    32'(res_op),    32'(bp_op[0]));
            chk("bp_dp_op",     32'({s1, s0}),  32'(bp_op[1]));
            chk("bp_dp_a",      32'(a),         32'(bp_a[1]));
            chk("bp_dp_b",      32'(b),         32'(bp_b[1]));
            step();
        end
        xfer0     = n_xfer;
        res_ready = 1'b1;
        step();
        chk("bp_ready_back", 32'(cmd_ready), 32'd1);
        drain(50);
        chk("bp_xfer_count", 32'(n_xfer - xfer0), 32'(DEPTH + 2));

        // self-check: stuck-at-zero datapath result is flagged
        chk("err_cnt_pre", 32'(err_cnt), 32'd0);
        force_zero = 1'b1;
        basic("selfchk", 2'b01, 3'b001, 3'b001, 3'b000, 1'b0, 1'b1);
        chk("err_cnt_one", 32'(err_cnt), 32'd1);

        // saturation: push well beyond the counter range
        res_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b01;
            cmd_a     = 3'b001;
            cmd_b     = 3'b001;
            step();
        end
        drain(50);
        force_zero = 1'b0;
        chk("err_cnt_sat_model", 32'(err_cnt), 32'(sat_err()));
        chk("err_cnt_sat",       32'(err_cnt), 32'(ERR_MAX));

        // random push/pop with random backpressure
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom);
            cmd_a     = 3'($urandom);
            cmd_b     = 3'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain(100);
        chk("err_cnt_after_rand", 32'(err_cnt), 32'(sat_err()));

        // reset with 5 commands in flight
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom);
            cmd_a     = 3'($urandom);
            cmd_b     = 3'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        chk("mid_inflight", 32'(n_pushed - n_xfer), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        n_pushed  = 0;
        n_xfer    = 0;
        n_err_exp = 0;
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_err_cnt",   32'(err_cnt),   32'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mid_no_stale", 32'(res_valid), 32'd0);
        end
        basic("post_rst", 2'b10, 3'b011, 3'b100, 3'b111, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
